// File: rtl/regfile_pkg.sv
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared widths, zero-register address and word/address typedefs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;
  localparam int DEFAULT_DEPTH  = 2 ** DEFAULT_ADDR_W;
  localparam int DEFAULT_NUM_RD = 2;
  localparam int ZERO_ADDR      = 0;

  typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEFAULT_DATA_W-1:0] reg_word_t;

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : Busy bit per register; alloc sets, write-back clears, alloc wins.
//            Optional macro REGFILE_BYPASS_EN forwards same-cycle clears.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int NUM_RD   = DEFAULT_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_alloc_en,
  input  logic [ADDR_W-1:0]        i_alloc_addr,
  input  logic                     i_clr0_en,
  input  logic [ADDR_W-1:0]        i_clr0_addr,
  input  logic                     i_clr1_en,
  input  logic [ADDR_W-1:0]        i_clr1_addr,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD-1:0]        o_rd_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] r_busy;
  logic             w_alloc_ok;

  assign w_alloc_ok = i_alloc_en &&
                      !((ZERO_REG != 0) && (i_alloc_addr == ADDR_W'(ZERO_ADDR)));

  // Alloc is applied last so a new producer supersedes a retiring one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      if (i_clr0_en) r_busy[i_clr0_addr] <= 1'b0;
      if (i_clr1_en) r_busy[i_clr1_addr] <= 1'b0;
      if (w_alloc_ok) r_busy[i_alloc_addr] <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_lookup
    logic [ADDR_W-1:0] w_addr;
    logic              w_busy;
    assign w_addr = i_rd_addr[gi*ADDR_W +: ADDR_W];

    always_comb begin
      w_busy = r_busy[w_addr];
`ifdef REGFILE_BYPASS_EN
      if ((i_clr0_en && (i_clr0_addr == w_addr)) ||
          (i_clr1_en && (i_clr1_addr == w_addr)))
        w_busy = i_alloc_en && (i_alloc_addr == w_addr);
`endif
      if ((ZERO_REG != 0) && (w_addr == ADDR_W'(ZERO_ADDR)))
        w_busy = 1'b0;
    end

    assign o_rd_busy[gi] = w_busy;
  end

endmodule

`default_nettype wire

// File: rtl/regfile_sb.sv
// ============================================================================
// Module   : regfile_sb
// Brief    : Multi-port register file with two write-back ports and a busy
//            scoreboard. Macro REGFILE_BYPASS_EN enables write-to-read forwarding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int NUM_RD   = DEFAULT_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  output logic                     wr_conflict
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_conflict;
  logic              w_wr0_ok;
  logic              w_wr1_ok;

  assign w_wr0_ok = wr0_en && !((ZERO_REG != 0) && (wr0_addr == ADDR_W'(ZERO_ADDR)));
  assign w_wr1_ok = wr1_en && !((ZERO_REG != 0) && (wr1_addr == ADDR_W'(ZERO_ADDR)));

  // wr1 is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_conflict <= 1'b0;
    end else begin
      if (w_wr0_ok) r_mem[wr0_addr] <= wr0_data;
      if (w_wr1_ok) r_mem[wr1_addr] <= wr1_data;
      if (w_wr0_ok && w_wr1_ok && (wr0_addr == wr1_addr)) r_conflict <= 1'b1;
    end
  end

  assign wr_conflict = r_conflict;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    assign w_addr = rd_addr[gi*ADDR_W +: ADDR_W];

    always_comb begin
      w_data = r_mem[w_addr];
`ifdef REGFILE_BYPASS_EN
      if (wr1_en && (wr1_addr == w_addr))      w_data = wr1_data;
      else if (wr0_en && (wr0_addr == w_addr)) w_data = wr0_data;
`endif
      if ((ZERO_REG != 0) && (w_addr == ADDR_W'(ZERO_ADDR)))
        w_data = '0;
    end

    assign rd_data[gi*DATA_W +: DATA_W] = w_data;
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .i_alloc_en   (alloc_en),
    .i_alloc_addr (alloc_addr),
    .i_clr0_en    (wr0_en),
    .i_clr0_addr  (wr0_addr),
    .i_clr1_en    (wr1_en),
    .i_clr1_addr  (wr1_addr),
    .i_rd_addr    (rd_addr),
    .o_rd_busy    (rd_busy)
  );

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================================
// Module   : tb_regfile_sb
// Brief    : Directed self-checking bench for regfile_sb (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [NUM_RD*ADDR_W-1:0] rd_addr = '0;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     alloc_en = 1'b0;
  logic [ADDR_W-1:0]        alloc_addr = '0;
  logic                     wr0_en = 1'b0;
  logic [ADDR_W-1:0]        wr0_addr = '0;
  logic [DATA_W-1:0]        wr0_data = '0;
  logic                     wr1_en = 1'b0;
  logic [ADDR_W-1:0]        wr1_addr = '0;
  logic [DATA_W-1:0]        wr1_data = '0;
  logic                     wr_conflict;

  int checks = 0;
  int errors = 0;

  regfile_sb dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .alloc_en    (alloc_en),
    .alloc_addr  (alloc_addr),
    .wr0_en      (wr0_en),
    .wr0_addr    (wr0_addr),
    .wr0_data    (wr0_data),
    .wr1_en      (wr1_en),
    .wr1_addr    (wr1_addr),
    .wr1_data    (wr1_data),
    .wr_conflict (wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  task automatic idle();
    alloc_en = 1'b0;
    wr0_en   = 1'b0;
    wr1_en   = 1'b0;
  endtask

  initial begin
    // Reset, then sweep every address on both ports
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      set_rd(ADDR_W'(a), ADDR_W'(31 - a));
      chk("rst_data0", 64'(rd_data[31:0]), 64'h0);
      chk("rst_data1", 64'(rd_data[63:32]), 64'h0);
      chk("rst_busy", 64'(rd_busy), 64'h0);
    end
    chk("rst_conflict", 64'(wr_conflict), 64'h0);

    // Plain write, visible next cycle on both ports
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
    tick();
    idle();
    set_rd(5'd5, 5'd5);
    chk("wr_r5_p0", 64'(rd_data[31:0]), 64'hDEADBEEF);
    chk("wr_r5_p1", 64'(rd_data[63:32]), 64'hDEADBEEF);

    // Register 0 ignores writes and allocations
    wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'h1234;
    alloc_en = 1'b1; alloc_addr = 5'd0;
    tick();
    idle();
    set_rd(5'd0, 5'd5);
    chk("r0_data", 64'(rd_data[31:0]), 64'h0);
    chk("r0_busy", 64'(rd_busy), 64'h0);

    // Scoreboard: alloc, clear by wr1, then alloc+write same cycle
    alloc_en = 1'b1; alloc_addr = 5'd7;
    tick();
    idle();
    set_rd(5'd5, 5'd7);
    chk("alloc_r7_busy", 64'(rd_busy), 64'b10);
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'hA5A5A5A5;
    tick();
    idle();
    #1;
    chk("wr1_r7_busy", 64'(rd_busy), 64'b00);
    chk("wr1_r7_data", 64'(rd_data[63:32]), 64'hA5A5A5A5);
    alloc_en = 1'b1; alloc_addr = 5'd7;
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h0000_0077;
    tick();
    idle();
    #1;
    chk("alloc_wins_busy", 64'(rd_busy), 64'b10);
    chk("alloc_wins_data", 64'(rd_data[63:32]), 64'h77);

    // Both write ports to r0 must not flag a conflict
    wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'h1;
    wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'h2;
    tick();
    idle();
    #1;
    chk("r0_no_conflict", 64'(wr_conflict), 64'h0);

    // Conflict on r9: wr1 wins, flag is sticky
    wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h1111;
    wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h2222;
    tick();
    idle();
    set_rd(5'd9, 5'd9);
    chk("conflict_data", 64'(rd_data[31:0]), 64'h2222);
    chk("conflict_flag", 64'(wr_conflict), 64'h1);
    tick();
    tick();
    chk("conflict_sticky", 64'(wr_conflict), 64'h1);

    // Same-cycle read of a register being written
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h33;
    tick();
    idle();
    alloc_en = 1'b1; alloc_addr = 5'd3;
    tick();
    idle();
    set_rd(5'd3, 5'd3);
    chk("pre_bypass_busy", 64'(rd_busy), 64'b11);
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'hCAFEF00D;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_data", 64'(rd_data[31:0]), 64'hCAFEF00D);
    chk("bypass_busy", 64'(rd_busy), 64'b00);
`else
    chk("nobypass_data", 64'(rd_data[31:0]), 64'h33);
    chk("nobypass_busy", 64'(rd_busy), 64'b11);
`endif
    tick();
    idle();
    #1;
    chk("post_write_data", 64'(rd_data[31:0]), 64'hCAFEF00D);
    chk("post_write_busy", 64'(rd_busy), 64'b00);

    // Reset overrides a simultaneous write and alloc
    wr0_en = 1'b1; wr0_addr = 5'd4; wr0_data = 32'h44;
    tick();
    idle();
    rst = 1'b1;
    wr0_en = 1'b1; wr0_addr = 5'd4; wr0_data = 32'h99;
    alloc_en = 1'b1; alloc_addr = 5'd4;
    tick();
    rst = 1'b0;
    idle();
    set_rd(5'd4, 5'd9);
    chk("rst_mid_data", 64'(rd_data[31:0]), 64'h0);
    chk("rst_mid_r9", 64'(rd_data[63:32]), 64'h0);
    chk("rst_mid_busy", 64'(rd_busy), 64'h0);
    chk("rst_mid_conflict", 64'(wr_conflict), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port general-purpose register file with per-register scoreboard, for the processor datapath that executes assembler-generated instructions. Provides `NUM_RD` asynchronous read ports and two synchronous write-back ports. A busy bit per register tracks in-flight producers, so the issue stage can detect RAW hazards. Register 0 is optionally hard-wired to zero.

## Interface
- `DATA_W`, 32: register width in bits.
- `ADDR_W`, 5: address width; depth is 2**ADDR_W.
- `NUM_RD`, 2: number of read ports, 1..4.
- `ZERO_REG`, 1: when 1, register 0 always reads 0 and ignores writes and allocations.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rd_addr` in NUM_RD*ADDR_W: packed read addresses; port i is bits [i*ADDR_W +: ADDR_W].
- `rd_data` out NUM_RD*DATA_W: packed read data.
- `rd_busy` out NUM_RD: scoreboard busy bit of each read address.
- `alloc_en` in 1: marks a destination register busy (instruction issued).
- `alloc_addr` in ADDR_W: destination being allocated.
- `wr0_en`, `wr0_addr`, `wr0_data` in 1/ADDR_W/DATA_W: write-back port 0 (ALU).
- `wr1_en`, `wr1_addr`, `wr1_data` in 1/ADDR_W/DATA_W: write-back port 1 (load/store unit).
- `wr_conflict` out 1: sticky flag, set when both write ports target the same non-zero register in one cycle.

## Operation
- Storage: 2**ADDR_W registers × DATA_W bits, plus 2**ADDR_W busy bits.
- Reads are combinational from `rd_addr` to `rd_data` and `rd_busy`.
- Writes commit on the rising edge when `wrN_en` = 1.
- Same address on both write ports:
  - `wr1` data wins.
  - `wr_conflict` is set on that edge and stays set until `rst`.
- Busy bits:
  - A write on either port clears the busy bit of its address.
  - `alloc_en` sets the busy bit of `alloc_addr`.
  - If alloc and a write hit the same address in one cycle, alloc wins and the bit ends at 1 (a new producer supersedes the old one).
- With `ZERO_REG` = 1, address 0 has these fixed properties:
  - `rd_data` = 0 and `rd_busy` = 0.
  - Writes and allocations to address 0 are dropped.
  - Writes to address 0 never set `wr_conflict`.
- With `ZERO_REG` = 0, register 0 is an ordinary register.
- Reset:
  - On a `rst` edge, all registers become 0, all busy bits become 0 and `wr_conflict` becomes 0.
  - Reset overrides any simultaneous write or alloc.
  - Consequently `rd_data` = 0 and `rd_busy` = 0 for every address after reset.
- No state machine beyond the storage. All state is edge-updated; there are no latches or combinational writes.

## Timing
- Read latency: 0 cycles (combinational).
- Write-to-read latency: 1 cycle. Data written at edge N is visible on `rd_data` after edge N, unless bypass is enabled (see Configuration).
- Alloc-to-busy latency: `rd_busy` rises after the edge that samples `alloc_en`.
- Write-to-not-busy latency: `rd_busy` falls after the write edge, unless bypass is enabled.
- `wr_conflict` rises after the offending edge.

## Configuration
- `REGFILE_BYPASS_EN` defined: same-cycle write-to-read forwarding.
  - When `wrN_en` targets a read port's address, that port's `rd_data` returns the `wrN_data` combinationally, and its `rd_busy` reads 0 in that cycle.
  - If both write ports match, `wr1` has priority.
  - A simultaneous alloc to the same address does not block the forwarded data. However, `rd_busy` reads 1, because the alloc wins for the next cycle.
  - The zero-register rule still applies.
- `REGFILE_BYPASS_EN` not defined: no forwarding. Reads return the pre-edge stored value and busy state.

## Structure
- Shared package `regfile_pkg`:
  - default widths and depth constants;
  - the `ZERO_ADDR` constant;
  - a typedef for a register address and a register word.
- One sub-module, `regfile_scoreboard`: busy-bit array with alloc/clear priority and `NUM_RD` lookup ports.
- The data array and write arbitration stay in `regfile_sb`.

## Test plan
- Reset then read: pulse `rst`, read all 32 addresses on every port -> `rd_data` = 0, `rd_busy` = 0, `wr_conflict` = 0.
- Write/read: `wr0` writes 0xDEADBEEF to r5 -> the next cycle both ports read 0xDEADBEEF at r5. Then write 0x1234 to r0 -> r0 still reads 0.
- Scoreboard:
  - alloc r7 -> `rd_busy` = 1 next cycle;
  - `wr1` writes 0xA5A5A5A5 to r7 -> busy = 0 next cycle;
  - alloc r7 and `wr0` r7 in the same cycle -> busy = 1 and data updated.
- Conflict: `wr0` writes 0x1111 and `wr1` writes 0x2222 to r9 in the same cycle -> r9 = 0x2222 and `wr_conflict` = 1 until `rst`.
- Bypass (macro on): `rd_addr` = r3 while `wr0` writes 0xCAFEF00D to r3 -> same-cycle `rd_data` = 0xCAFEF00D. With the macro off -> old value, new value the next cycle.
- Reset mid-operation: `rst` asserted together with `wr0` to r4 and alloc r4 -> after the edge r4 = 0 and busy = 0.
